// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit between the ALU and a valid/ready data bus.
// Aligns and extends loads, replicates store lanes, stalls the core and reports faults.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_MIS = 2'b01;
    localparam logic [1:0] ERR_F3  = 2'b10;
    localparam logic [1:0] ERR_TO  = 2'b11;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 32'd1);

    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we) begin
            return f3 > 3'b010;
        end else begin
            return (f3 == 3'b011) || (f3[2:1] == 2'b11);
        end
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b01:   return a[0];
            2'b10:   return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(d >> {a, 3'b000});
        h = a[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return d;
        endcase
    endfunction

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        bus_valid_q, bus_valid_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]  rsp_err_q, rsp_err_d;

    // Next-state, request latch, timeout counter and response capture
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rsp_err_d   = ERR_OK;
        rsp_rdata_d = 32'd0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (f3_illegal(req_we, req_funct3)) begin
                        state_d   = RESP;
                        rsp_err_d = ERR_F3;
                    end else if (misaligned(req_funct3[1:0], req_addr[1:0])) begin
                        state_d   = RESP;
                        rsp_err_d = ERR_MIS;
                    end else begin
                        state_d = ADDR;
                        cnt_d   = 8'd0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR: begin
                cnt_d = cnt_q + 8'd1;
                // A handshake on the final allowed cycle still completes the access
                if (bus_ready) begin
                    state_d = we_q ? RESP : WAIT;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = RESP;
                    rsp_err_d = ERR_TO;
                end else begin
                    state_d = ADDR;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (bus_rvalid) begin
                    state_d     = RESP;
                    rsp_rdata_d = load_extract(f3_q, addr_q[1:0], bus_rdata);
                end else if (cnt_q == TO_LAST) begin
                    state_d   = RESP;
                    rsp_err_d = ERR_TO;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus and response outputs registered from the next state
    always_comb begin
        bus_valid_d = (state_d == ADDR);
        rsp_valid_d = (state_d == RESP);
        if (state_d == ADDR) begin
            bus_we_d    = we_d;
            bus_addr_d  = {addr_d[31:2], 2'b00};
            bus_be_d    = we_d ? store_be(f3_d[1:0], addr_d[1:0]) : 4'b0000;
            bus_wdata_d = we_d ? store_data(f3_d[1:0], wdata_d) : 32'd0;
        end else begin
            bus_we_d    = 1'b0;
            bus_addr_d  = 32'd0;
            bus_be_d    = 4'b0000;
            bus_wdata_d = 32'd0;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            cnt_q       <= 8'd0;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 2'b00;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            bus_valid_q <= bus_valid_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Stall is gated by reset so the core sees no stall while reset is held
    assign stall = rst & (((state_q == IDLE) & req_valid) | (state_q == ADDR) | (state_q == WAIT));

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign bus_valid = bus_valid_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a small cycle-driven bus responder.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int total = 0;
    int bad   = 0;

    int          o_lat;
    int          o_stalls;
    logic [31:0] o_rdata;
    logic [1:0]  o_err;
    logic        cap_seen;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .stall     (stall),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_rvalid(bus_rvalid),
        .bus_rdata (bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one request at a negedge in IDLE; rdy_dly/rv_dly < 0 means never respond.
    // Latency is counted in cycles from the accept cycle (cycle 0).
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int rdy_dly, input int rv_dly,
                          input logic [31:0] rdata);
        int cyc;
        int acnt;
        int wcnt;
        bit in_wait;
        bit done;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        bus_rdata  = rdata;
        cyc = 0; acnt = 0; wcnt = 0; in_wait = 1'b0; done = 1'b0;
        o_lat = -1; o_stalls = 0; o_rdata = 32'hxxxx_xxxx; o_err = 2'bxx; cap_seen = 1'b0;
        while (!done && cyc < 60) begin
            if (rsp_valid) begin
                o_lat   = cyc;
                o_rdata = rsp_rdata;
                o_err   = rsp_err;
                done    = 1'b1;
            end else begin
                if (cyc > 0 && stall) o_stalls++;
                if (bus_valid && !cap_seen) begin
                    cap_seen  = 1'b1;
                    cap_we    = bus_we;
                    cap_addr  = bus_addr;
                    cap_be    = bus_be;
                    cap_wdata = bus_wdata;
                end
                bus_ready  = bus_valid && rdy_dly >= 0 && acnt >= rdy_dly;
                bus_rvalid = in_wait && rv_dly >= 0 && wcnt >= rv_dly;
                if (bus_valid) acnt++;
                if (in_wait) wcnt++;
                if (bus_ready && !we) in_wait = 1'b1;
                step();
                cyc++;
            end
        end
        req_valid  = 1'b0;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        step();
        check("rsp_pulse_end", 32'(rsp_valid), 32'd0);
        check("idle_bus_valid", 32'(bus_valid), 32'd0);
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        req_wdata  = 32'h1234_5678;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'd0;

        // Reset held two cycles with a pending request
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_bus_valid", 32'(bus_valid), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_be", 32'(bus_be), 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        rst       = 1'b1;
        req_valid = 1'b0;
        repeat (2) begin
            step();
            check("post_rst_bus_valid", 32'(bus_valid), 32'd0);
            check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        end

        // LB / LBU / LH / LHU / LW on word 0x80FF_1234
        do_req(1'b0, 3'b000, 32'h103, 32'd0, 0, 0, 32'h80FF_1234);
        check("lb_lat", 32'(o_lat), 32'd3);
        check("lb_rdata", o_rdata, 32'hFFFF_FF80);
        check("lb_err", 32'(o_err), 32'd0);
        check("lb_bus_addr", cap_addr, 32'h100);
        check("lb_bus_be", 32'(cap_be), 32'd0);
        check("lb_bus_we", 32'(cap_we), 32'd0);
        check("lb_bus_wdata", cap_wdata, 32'd0);
        do_req(1'b0, 3'b100, 32'h103, 32'd0, 0, 0, 32'h80FF_1234);
        check("lbu_rdata", o_rdata, 32'h0000_0080);
        do_req(1'b0, 3'b000, 32'h101, 32'd0, 0, 0, 32'h80FF_1234);
        check("lb1_rdata", o_rdata, 32'h0000_0012);
        do_req(1'b0, 3'b001, 32'h102, 32'd0, 0, 0, 32'h80FF_1234);
        check("lh_rdata", o_rdata, 32'hFFFF_80FF);
        do_req(1'b0, 3'b101, 32'h100, 32'd0, 0, 0, 32'h80FF_1234);
        check("lhu_rdata", o_rdata, 32'h0000_1234);
        do_req(1'b0, 3'b010, 32'h104, 32'd0, 0, 2, 32'h80FF_1234);
        check("lw_rvwait_lat", 32'(o_lat), 32'd5);
        check("lw_rdata", o_rdata, 32'h80FF_1234);

        // Stores
        do_req(1'b1, 3'b001, 32'h42, 32'h0000_BEEF, 3, -1, 32'd0);
        check("sh_lat", 32'(o_lat), 32'd5);
        check("sh_stalls", 32'(o_stalls), 32'd4);
        check("sh_err", 32'(o_err), 32'd0);
        check("sh_rdata", o_rdata, 32'd0);
        check("sh_bus_be", 32'(cap_be), 32'hC);
        check("sh_bus_wdata", cap_wdata, 32'hBEEF_BEEF);
        check("sh_bus_addr", cap_addr, 32'h40);
        check("sh_bus_we", 32'(cap_we), 32'd1);
        do_req(1'b1, 3'b000, 32'h201, 32'h1234_5678, 0, -1, 32'd0);
        check("sb_lat", 32'(o_lat), 32'd2);
        check("sb_bus_be", 32'(cap_be), 32'h2);
        check("sb_bus_wdata", cap_wdata, 32'h7878_7878);
        check("sb_bus_addr", cap_addr, 32'h200);
        do_req(1'b1, 3'b010, 32'h300, 32'hDEAD_BEEF, 0, -1, 32'd0);
        check("sw_bus_be", 32'(cap_be), 32'hF);
        check("sw_bus_wdata", cap_wdata, 32'hDEAD_BEEF);

        // Faults
        do_req(1'b0, 3'b010, 32'h6, 32'd0, 0, 0, 32'hFFFF_FFFF);
        check("mis_lat", 32'(o_lat), 32'd1);
        check("mis_err", 32'(o_err), 32'd1);
        check("mis_rdata", o_rdata, 32'd0);
        check("mis_no_bus", 32'(cap_seen), 32'd0);
        do_req(1'b1, 3'b011, 32'h8, 32'h1, 0, -1, 32'd0);
        check("st_f3_err", 32'(o_err), 32'd2);
        check("st_f3_lat", 32'(o_lat), 32'd1);
        check("st_f3_no_bus", 32'(cap_seen), 32'd0);
        do_req(1'b0, 3'b110, 32'h1, 32'd0, 0, 0, 32'd0);
        check("f3_over_mis_err", 32'(o_err), 32'd2);
        do_req(1'b1, 3'b101, 32'h2, 32'd0, 0, -1, 32'd0);
        check("st_f3_101_err", 32'(o_err), 32'd2);

        // Timeouts and the handshake-wins boundary
        do_req(1'b0, 3'b010, 32'h20, 32'd0, 0, -1, 32'd0);
        check("to_wait_lat", 32'(o_lat), 32'd17);
        check("to_wait_err", 32'(o_err), 32'd3);
        check("to_wait_rdata", o_rdata, 32'd0);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hAAAA_5555;
        repeat (2) begin
            step();
            check("late_rvalid_rsp", 32'(rsp_valid), 32'd0);
            check("late_rvalid_stall", 32'(stall), 32'd0);
        end
        bus_rvalid = 1'b0;
        do_req(1'b1, 3'b010, 32'h24, 32'h5, -1, -1, 32'd0);
        check("to_addr_lat", 32'(o_lat), 32'd17);
        check("to_addr_err", 32'(o_err), 32'd3);
        do_req(1'b0, 3'b010, 32'h28, 32'd0, 0, 14, 32'h0BAD_F00D);
        check("edge_hs_lat", 32'(o_lat), 32'd17);
        check("edge_hs_err", 32'(o_err), 32'd0);
        check("edge_hs_rdata", o_rdata, 32'h0BAD_F00D);
        do_req(1'b0, 3'b010, 32'h28, 32'd0, 0, 15, 32'h0BAD_F00D);
        check("edge_to_err", 32'(o_err), 32'd3);
        check("edge_to_rdata", o_rdata, 32'd0);

        // Reset during WAIT aborts the access silently
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h30;
        step();
        check("rw_addr_bus_valid", 32'(bus_valid), 32'd1);
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        check("rw_wait_bus_valid", 32'(bus_valid), 32'd0);
        check("rw_wait_stall", 32'(stall), 32'd1);
        rst = 1'b0;
        step();
        check("rw_rst_bus_valid", 32'(bus_valid), 32'd0);
        check("rw_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rw_rst_stall", 32'(stall), 32'd0);
        rst       = 1'b1;
        req_valid = 1'b0;
        bus_rvalid = 1'b1;
        repeat (3) begin
            step();
            check("rw_after_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        bus_rvalid = 1'b0;
        do_req(1'b0, 3'b010, 32'h10, 32'd0, 0, 0, 32'hCAFE_F00D);
        check("rw_lw_lat", 32'(o_lat), 32'd3);
        check("rw_lw_rdata", o_rdata, 32'hCAFE_F00D);
        check("rw_lw_err", 32'(o_err), 32'd0);
        check("rw_lw_bus_addr", cap_addr, 32'h10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit that sits directly downstream of the core's ALU and replaces the ideal single-cycle data memory path. It takes the ALU-computed address, rs2 store data and funct3, and runs a valid/ready transaction on a word-addressed data bus with byte lanes. It aligns and extends load data, and stalls the core until the access completes or faults. Faults are misalignment, illegal funct3 or bus timeout.

## Interface
- TIMEOUT, 16: max cycles spent in ADDR+WAIT before the access is aborted with a timeout fault (range 2..255).
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset; synchronous and active-low.
- req_valid  in  1  core presents a memory instruction; held stable while stall=1.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data (rs2).
- stall  out  1  hold PC and inhibit register write.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and faults.
- rsp_err  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout; valid with rsp_valid.
- bus_valid  out  1  bus request.
- bus_ready  in  1  bus accepts request.
- bus_we  out  1  bus write.
- bus_addr  out  32  word address, {addr[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_rvalid  in  1  load data return.
- bus_rdata  in  32  returned word.

## Operation
- FSM states: IDLE, ADDR, WAIT, RESP.
- IDLE, req_valid=1: latch we/funct3/addr/wdata.
  - Illegal funct3 (load 011/110/111; store ≥011) → RESP, err 10.
  - Misaligned (half with addr[0]=1; word with addr[1:0]≠0) → RESP, err 01.
  - Otherwise → ADDR.
  - Illegal funct3 takes priority over misalignment.
- ADDR: bus_valid=1, all bus_* outputs held from latched request.
  - bus_ready=1: store → RESP; load → WAIT.
- WAIT: bus_valid=0; bus_rvalid=1 → capture bus_rdata, → RESP.
- Timeout counter: cleared on entry to ADDR, increments each cycle in ADDR/WAIT. Reaching TIMEOUT → RESP, err 11, bus_valid drops.
- RESP: rsp_valid=1, stall=0, then → IDLE.
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{byte}}.
  - SH: be=addr[1]?1100:0011, wdata={2{half}}.
  - SW: be=1111.
- Load extract: byte lane addr[1:0] / half lane addr[1]. Sign-extend for LB/LH, zero-extend for LBU/LHU; LW passes the word through.
- bus_be=0 and bus_we=0 for loads.

## Timing
- Reset (rst=0 at edge): state IDLE, counter 0, latched regs 0. All outputs 0: stall, rsp_valid, rsp_rdata, rsp_err, bus_valid, bus_we, bus_addr, bus_be, bus_wdata.
- Reset mid-transaction aborts the access; no rsp_valid is produced.
- stall is combinational: 1 in IDLE when req_valid=1, 1 in ADDR and WAIT, 0 in RESP.
- Latency from the accept edge, zero-wait bus:
  - Store: rsp_valid in cycle 2.
  - Load: rsp_valid in cycle 3.
  - Fault: rsp_valid in cycle 1.
  - Each bus_ready or bus_rvalid wait cycle adds one.
- bus_rvalid is sampled only in WAIT; rvalid in ADDR, RESP or IDLE (including late data after a timeout) is ignored.
- Back-to-back requests: the next request is accepted in IDLE on the cycle after RESP.
- Timeout on the cycle bus_ready/bus_rvalid arrives: the handshake wins and the access completes normally.

## Test plan
- Reset: rst=0 for 2 cycles with req_valid=1 → all outputs 0; release → IDLE, nothing issued until the next request.
- LB addr 0x103, bus_rdata 0x80FF_1234 → be=0, bus_addr 0x100, rsp_rdata 0xFFFF_FF80 in cycle 3. LBU on the same word → 0x0000_0080.
- SH addr 0x42, wdata 0x0000_BEEF, bus_ready delayed 3 cycles → bus_be=1100, bus_wdata 0xBEEF_BEEF, stall held 4 cycles, rsp_valid cycle 5, err 00.
- LW addr 0x6 → no bus_valid, rsp_valid cycle 1, err 01, rdata 0. Store funct3=011 → err 10.
- TIMEOUT=16, load with bus_rvalid never asserted → rsp_err 11 exactly 16 cycles after entering ADDR. rvalid pulsed afterwards in IDLE → ignored.
- Reset asserted during WAIT → next cycle IDLE, bus_valid 0, no rsp_valid. A following LW 0x10 completes normally.
